// File: rtl/hb_decim_mc_if.sv
// Handshake bundle for hb_decim_mc: sample input stream, decimated output
// stream and the sticky saturation indicator.
//   slave  : view taken by the decimator (consumes s_*, produces m_*)
//   master : view taken by the surrounding logic / bench
interface hb_decim_mc_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CH_W   = 1
);
  logic signed [DATA_W-1:0] s_data;
  logic        [CH_W-1:0]   s_chan;
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] m_data;
  logic        [CH_W-1:0]   m_chan;
  logic                     m_valid;
  logic                     m_ready;
  logic                     sat_flag;

  modport slave (
    input  s_data, s_chan, s_valid, m_ready,
    output s_ready, m_data, m_chan, m_valid, sat_flag
  );

  modport master (
    output s_data, s_chan, s_valid, m_ready,
    input  s_ready, m_data, m_chan, m_valid, sat_flag
  );
endinterface

// File: rtl/hb_decim_mc.sv
// hb_decim_mc: multi-channel half-band decimate-by-2 FIR with one shared
// multiplier. Each channel keeps its own delay line, fill count and phase.
// A due output is computed over NU+1 MAC cycles, then held on m_* until
// accepted. Input is stalled (s_ready low) while an output is in flight.
//   clk, reset_n : clock, asynchronous active-low reset
//   bus (slave)  : s_data/s_chan/s_valid/s_ready input stream,
//                  m_data/m_chan/m_valid/m_ready output stream, sat_flag
// Build option: define HB_DECIM_ROUND_EN for round-half-up on the final
// shift; otherwise the result is truncated (floor).
module hb_decim_mc #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned COEF_W = 16,
  parameter int unsigned NCH    = 2,
  parameter int unsigned NTAPS  = 27,
  // {3, -28, 128, -415, 1107, -2778, 10176}; entry 0 is the outermost tap
  parameter logic [((NTAPS+1)/4)*COEF_W-1:0] COEFS = {
    16'h0003, 16'hFFE4, 16'h0080, 16'hFE61, 16'h0453, 16'hF526, 16'h27C0}
) (
  input  logic          clk,
  input  logic          reset_n,
  hb_decim_mc_if.slave  bus
);

  localparam int unsigned NU     = (NTAPS + 1) / 4;
  localparam int unsigned CH_W   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned FILL_W = $clog2(NTAPS + 2);
  localparam int unsigned CNT_W  = $clog2(NU + 1);
  localparam int unsigned PRE_W  = DATA_W + 1;
  localparam int unsigned PROD_W = PRE_W + COEF_W;
  localparam int unsigned ACC_W  = DATA_W + COEF_W + $clog2(NU + 1) + 1;
  localparam int unsigned CTR    = (NTAPS - 1) / 2;
  localparam int unsigned SH     = COEF_W - 1;

  localparam logic signed [COEF_W-1:0] CENTER  = COEF_W'(1) << (COEF_W - 2);
  localparam logic signed [ACC_W-1:0]  SAT_MAX = (ACC_W'(1) << (DATA_W - 1)) - ACC_W'(1);
  localparam logic signed [ACC_W-1:0]  SAT_MIN = -SAT_MAX - ACC_W'(1);
`ifdef HB_DECIM_ROUND_EN
  localparam logic signed [ACC_W-1:0]  RND = ACC_W'(1) << (COEF_W - 2);
`else
  localparam logic signed [ACC_W-1:0]  RND = '0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_MAC, ST_OUT} state_t;

  state_t state_q, state_d;

  logic signed [DATA_W-1:0] dl_q [NCH][NTAPS];
  logic        [FILL_W-1:0] fill_q [NCH];
  logic                     phase_q [NCH];
  logic        [CH_W-1:0]   cur_ch_q;
  logic        [CNT_W-1:0]  cnt_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [DATA_W-1:0] m_data_q;
  logic        [CH_W-1:0]   m_chan_q;
  logic                     m_valid_q;
  logic                     sat_q;
  logic                     s_ready_q;

  logic                     chan_ok;
  logic                     accept;
  logic                     due;
  logic        [FILL_W-1:0] sel_fill;
  logic                     sel_phase;
  logic signed [DATA_W-1:0] line [NTAPS];
  logic signed [PRE_W-1:0]  pre;
  logic signed [COEF_W-1:0] coef;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  shifted;
  logic signed [DATA_W-1:0] res;
  logic                     res_sat;

  // Channel index range check; constant true when every code is a channel.
  generate
    if ((1 << CH_W) > NCH) begin : g_chk
      assign chan_ok = (bus.s_chan < CH_W'(NCH));
    end else begin : g_nochk
      assign chan_ok = 1'b1;
    end
  endgenerate

  assign accept = bus.s_valid && s_ready_q && chan_ok;

  // Fill/phase of the arriving sample's channel.
  always_comb begin
    sel_fill  = '0;
    sel_phase = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (CH_W'(c) == bus.s_chan) begin
        sel_fill  = fill_q[c];
        sel_phase = phase_q[c];
      end
    end
  end

  // Output due when this sample makes the count reach NTAPS+1 or beyond and
  // is even-numbered (old phase odd).
  assign due = accept && (sel_fill >= FILL_W'(NTAPS)) && sel_phase;

  // Shared MAC datapath: symmetric pre-add for cnt < NU, centre tap last.
  always_comb begin
    for (int t = 0; t < NTAPS; t++) line[t] = '0;
    for (int c = 0; c < NCH; c++) begin
      if (CH_W'(c) == cur_ch_q) begin
        for (int t = 0; t < NTAPS; t++) line[t] = dl_q[c][t];
      end
    end
    pre  = PRE_W'(line[CTR]);
    coef = CENTER;
    for (int t = 0; t < NU; t++) begin
      if (cnt_q == CNT_W'(t)) begin
        pre  = PRE_W'(line[2*t]) + PRE_W'(line[NTAPS-1-2*t]);
        coef = COEFS[(NU-1-t)*COEF_W +: COEF_W];
      end
    end
    prod = PROD_W'(pre) * PROD_W'(coef);
  end

  // Scale back to DATA_W and clamp.
  always_comb begin
    shifted = (acc_q + RND) >>> SH;
    res     = shifted[DATA_W-1:0];
    res_sat = 1'b0;
    if (shifted > SAT_MAX) begin
      res     = SAT_MAX[DATA_W-1:0];
      res_sat = 1'b1;
    end else if (shifted < SAT_MIN) begin
      res     = SAT_MIN[DATA_W-1:0];
      res_sat = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (due) state_d = ST_MAC;
      ST_MAC:  if (cnt_q == CNT_W'(NU)) state_d = ST_OUT;
      ST_OUT:  if (m_valid_q && bus.m_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Channel state, MAC accumulator and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) begin
        for (int t = 0; t < NTAPS; t++) dl_q[c][t] <= '0;
        fill_q[c]  <= '0;
        phase_q[c] <= 1'b0;
      end
      cur_ch_q  <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      m_data_q  <= '0;
      m_chan_q  <= '0;
      m_valid_q <= 1'b0;
      sat_q     <= 1'b0;
      s_ready_q <= 1'b1;
    end else begin
      s_ready_q <= (state_d == ST_IDLE);

      if (accept) begin
        for (int c = 0; c < NCH; c++) begin
          if (CH_W'(c) == bus.s_chan) begin
            for (int t = NTAPS - 1; t > 0; t--) dl_q[c][t] <= dl_q[c][t-1];
            dl_q[c][0] <= bus.s_data;
            if (fill_q[c] != FILL_W'(NTAPS + 1)) fill_q[c] <= fill_q[c] + FILL_W'(1);
            phase_q[c] <= ~phase_q[c];
          end
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (due) begin
            cur_ch_q <= bus.s_chan;
            cnt_q    <= '0;
            acc_q    <= '0;
          end
        end
        ST_MAC: begin
          acc_q <= acc_q + ACC_W'(prod);
          cnt_q <= cnt_q + CNT_W'(1);
        end
        ST_OUT: begin
          // First OUT cycle loads the result; it is then held until taken.
          if (!m_valid_q) begin
            m_valid_q <= 1'b1;
            m_data_q  <= res;
            m_chan_q  <= cur_ch_q;
            if (res_sat) sat_q <= 1'b1;
          end else if (bus.m_ready) begin
            m_valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready  = s_ready_q;
  assign bus.m_data   = m_data_q;
  assign bus.m_chan   = m_chan_q;
  assign bus.m_valid  = m_valid_q;
  assign bus.sat_flag = sat_q;

endmodule
